// File: rtl/vme_defs.sv
// Shared definitions for the VME master sequencer: strobe polarity, address
// modifier codes, sequencer states and the small encoding helpers.
package vme_defs;

    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    localparam int CNT_W = 10;

    localparam logic [5:0] AM_A16_SUP = 6'h2D;
    localparam logic [5:0] AM_A16_USR = 6'h29;
    localparam logic [5:0] AM_A24_SD  = 6'h3D;
    localparam logic [5:0] AM_A24_SP  = 6'h3E;
    localparam logic [5:0] AM_A24_UD  = 6'h39;
    localparam logic [5:0] AM_A24_UP  = 6'h3A;
    localparam logic [5:0] AM_A40     = 6'h34;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUS,
        ADDR,
        STROBE,
        WAIT_ACK,
        TERM_OK,
        TERM_ERR,
        RELEASE
    } seq_state_t;

    // fc[2] selects supervisor space, fc[1:0] == 10 marks a program fetch.
    function automatic logic [5:0] am_encode(input logic a16, input logic a24,
                                             input logic [2:0] fc);
        if (a16)
            return fc[2] ? AM_A16_SUP : AM_A16_USR;
        if (a24) begin
            if (fc[2])
                return (fc[1:0] == 2'b10) ? AM_A24_SP : AM_A24_SD;
            return (fc[1:0] == 2'b10) ? AM_A24_UP : AM_A24_UD;
        end
        return AM_A40;
    endfunction

    // Returns {DS1*, DS0*} for a 16-bit port: even byte on DS1, odd byte on DS0.
    function automatic logic [1:0] ds_encode(input logic [1:0] siz, input logic a0);
        if (siz == 2'b01 || a0)
            return a0 ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

endpackage

// File: rtl/vme_sync2.sv
// Two-flop synchroniser for an asynchronous active-low VME input; resets to
// the negated level so a freshly reset sequencer never sees a stale strobe.
module vme_sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vme_master_sequencer.sv
// Runs one CPU-initiated VME transfer to a D16 port once the bus is owned and
// terminates the CPU cycle with DSACK or BERR; every output is registered.
module vme_master_sequencer
    import vme_defs::*;
#(
    parameter int ADDR_SETUP = 2,
    parameter int DS_DELAY   = 1,
    parameter int TIMEOUT    = 1023
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       request_vme_a16,
    input  logic       request_vme_a24,
    input  logic       request_vme_a40,
    input  logic       bus_acquired,
    input  logic       cpu_as,
    input  logic       cpu_ds,
    input  logic       cpu_write,
    input  logic [1:0] cpu_siz,
    input  logic [1:0] cpu_address_low,
    input  logic [2:0] cpu_fc,
    output logic [1:0] cpu_dsack,
    output logic       cpu_dsack_oe,
    output logic       cpu_berr_out,
    output logic       vme_as,
    output logic       vme_write,
    output logic       vme_lword,
    output logic [1:0] vme_ds,
    output logic [5:0] vme_address_mod,
    output logic       vme_ctrl_oe,
    input  logic       vme_dtack,
    input  logic       vme_berr,
    output logic       addr_low_oe,
    output logic       a40_cross_oe,
    output logic       data_low_oe,
    output logic       d16_cross_oe,
    output logic       md32_cross_oe,
    output logic       data_low_dir,
    output logic       d16_cross_dir,
    output logic       md32_cross_dir
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(ADDR_SETUP - 1);
    localparam logic [CNT_W-1:0] DS_LAST    = CNT_W'(DS_DELAY - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       ds_pattern;
    logic             dtack_s;
    logic             berr_s;
    logic             abort;
    logic             unused_addr_bit;

    assign unused_addr_bit = cpu_address_low[1];

    vme_sync2 u_sync_dtack (.clock(clock), .reset(reset), .d(vme_dtack), .q(dtack_s));
    vme_sync2 u_sync_berr  (.clock(clock), .reset(reset), .d(vme_berr),  .q(berr_s));

    // The CPU dropping AS once we have started driving the bus ends the cycle early.
    always_comb begin
        abort = (cpu_as == INACTIVE) &&
                (state inside {ADDR, STROBE, WAIT_ACK, TERM_OK, TERM_ERR});
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            ds_pattern      <= 2'b11;
            cpu_dsack       <= 2'b11;
            cpu_dsack_oe    <= 1'b0;
            cpu_berr_out    <= INACTIVE;
            vme_as          <= INACTIVE;
            vme_write       <= INACTIVE;
            vme_lword       <= INACTIVE;
            vme_ds          <= 2'b11;
            vme_address_mod <= 6'h00;
            vme_ctrl_oe     <= 1'b0;
            addr_low_oe     <= INACTIVE;
            a40_cross_oe    <= INACTIVE;
            data_low_oe     <= INACTIVE;
            d16_cross_oe    <= INACTIVE;
            md32_cross_oe   <= INACTIVE;
            data_low_dir    <= 1'b0;
            d16_cross_dir   <= 1'b0;
            md32_cross_dir  <= 1'b0;
        end else if (abort) begin
            state        <= RELEASE;
            vme_as       <= INACTIVE;
            vme_ds       <= 2'b11;
            addr_low_oe  <= INACTIVE;
            a40_cross_oe <= INACTIVE;
            d16_cross_oe <= INACTIVE;
            cpu_dsack    <= 2'b11;
            cpu_dsack_oe <= 1'b0;
            cpu_berr_out <= INACTIVE;
        end else begin
            case (state)
                IDLE: begin
                    if ((request_vme_a16 || request_vme_a24 || request_vme_a40) &&
                        cpu_as == ACTIVE)
                        state <= WAIT_BUS;
                end
                WAIT_BUS: begin
                    if (cpu_as == INACTIVE) begin
                        state <= IDLE;
                    end else if (bus_acquired) begin
                        state           <= ADDR;
                        cnt             <= '0;
                        vme_ctrl_oe     <= 1'b1;
                        addr_low_oe     <= ACTIVE;
                        a40_cross_oe    <= request_vme_a40 ? ACTIVE : INACTIVE;
                        vme_address_mod <= am_encode(request_vme_a16, request_vme_a24, cpu_fc);
                        vme_write       <= cpu_write;
                        d16_cross_dir   <= !cpu_write;
                        ds_pattern      <= ds_encode(cpu_siz, cpu_address_low[0]);
                    end
                end
                ADDR: begin
                    if (cnt >= SETUP_LAST) begin
                        state        <= STROBE;
                        cnt          <= '0;
                        vme_as       <= ACTIVE;
                        a40_cross_oe <= INACTIVE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STROBE: begin
                    if (cnt >= DS_LAST && cpu_ds == ACTIVE) begin
                        state        <= WAIT_ACK;
                        cnt          <= '0;
                        vme_ds       <= ds_pattern;
                        d16_cross_oe <= ACTIVE;
                    end else if (cnt < DS_LAST) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                // BERR is tested before DTACK so it wins when both arrive together.
                WAIT_ACK: begin
                    if (berr_s == ACTIVE) begin
                        state        <= TERM_ERR;
                        cpu_berr_out <= ACTIVE;
                    end else if (dtack_s == ACTIVE) begin
                        state        <= TERM_OK;
                        cpu_dsack    <= 2'b01;
                        cpu_dsack_oe <= 1'b1;
                    end else if (cnt >= TO_LAST) begin
                        state        <= TERM_ERR;
                        cpu_berr_out <= ACTIVE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                TERM_OK, TERM_ERR: begin
                    state <= state;
                end
                RELEASE: begin
                    if (dtack_s == INACTIVE && berr_s == INACTIVE) begin
                        state       <= IDLE;
                        vme_ctrl_oe <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vme_master_sequencer.sv
// Self-checking bench for vme_master_sequencer: directed scenarios plus
// randomised transfers compared against clock-count and encoding rules.
module tb_vme_master_sequencer;

    localparam int ADDR_SETUP = 2;
    localparam int DS_DELAY   = 1;
    localparam int TIMEOUT    = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       request_vme_a16, request_vme_a24, request_vme_a40;
    logic       bus_acquired;
    logic       cpu_as, cpu_ds, cpu_write;
    logic [1:0] cpu_siz, cpu_address_low;
    logic [2:0] cpu_fc;
    logic [1:0] cpu_dsack;
    logic       cpu_dsack_oe, cpu_berr_out;
    logic       vme_as, vme_write, vme_lword;
    logic [1:0] vme_ds;
    logic [5:0] vme_address_mod;
    logic       vme_ctrl_oe;
    logic       vme_dtack, vme_berr;
    logic       addr_low_oe, a40_cross_oe, data_low_oe, d16_cross_oe, md32_cross_oe;
    logic       data_low_dir, d16_cross_dir, md32_cross_dir;

    int checks = 0;
    int errors = 0;

    logic [31:0] outVec;
    localparam logic [31:0] RESET_VEC = {8'h00, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                         2'b11, 6'h00, 1'b0, 5'b11111, 3'b000};

    assign outVec = {8'h00, cpu_dsack, cpu_dsack_oe, cpu_berr_out, vme_as, vme_write,
                     vme_lword, vme_ds, vme_address_mod, vme_ctrl_oe, addr_low_oe,
                     a40_cross_oe, data_low_oe, d16_cross_oe, md32_cross_oe,
                     data_low_dir, d16_cross_dir, md32_cross_dir};

    always #5 clock = ~clock;

    vme_master_sequencer #(
        .ADDR_SETUP(ADDR_SETUP),
        .DS_DELAY  (DS_DELAY),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .request_vme_a16(request_vme_a16),
        .request_vme_a24(request_vme_a24),
        .request_vme_a40(request_vme_a40),
        .bus_acquired   (bus_acquired),
        .cpu_as         (cpu_as),
        .cpu_ds         (cpu_ds),
        .cpu_write      (cpu_write),
        .cpu_siz        (cpu_siz),
        .cpu_address_low(cpu_address_low),
        .cpu_fc         (cpu_fc),
        .cpu_dsack      (cpu_dsack),
        .cpu_dsack_oe   (cpu_dsack_oe),
        .cpu_berr_out   (cpu_berr_out),
        .vme_as         (vme_as),
        .vme_write      (vme_write),
        .vme_lword      (vme_lword),
        .vme_ds         (vme_ds),
        .vme_address_mod(vme_address_mod),
        .vme_ctrl_oe    (vme_ctrl_oe),
        .vme_dtack      (vme_dtack),
        .vme_berr       (vme_berr),
        .addr_low_oe    (addr_low_oe),
        .a40_cross_oe   (a40_cross_oe),
        .data_low_oe    (data_low_oe),
        .d16_cross_oe   (d16_cross_oe),
        .md32_cross_oe  (md32_cross_oe),
        .data_low_dir   (data_low_dir),
        .d16_cross_dir  (d16_cross_dir),
        .md32_cross_dir (md32_cross_dir)
    );

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Address modifier from the address space and function code.
    function automatic logic [5:0] modelAm(input int space, input logic [2:0] fc);
        int am;
        case (space)
            0: am = fc[2] ? 'h2D : 'h29;
            1: begin
                am = fc[2] ? 'h3D : 'h39;
                if (fc[1:0] == 2'b10) am = am + 1;
            end
            default: am = 'h34;
        endcase
        return 6'(am);
    endfunction

    function automatic logic [1:0] modelDs(input logic [1:0] siz, input logic a0);
        if (siz == 2'b01 || a0 == 1'b1) return a0 ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    task automatic applyStimulus(input int space, input logic [2:0] fc, input logic [1:0] siz,
                                 input logic a0, input bit isWrite, input bit dsLow);
        request_vme_a16 = (space == 0);
        request_vme_a24 = (space == 1);
        request_vme_a40 = (space == 2);
        cpu_fc          = fc;
        cpu_siz         = siz;
        cpu_address_low = {1'b0, a0};
        cpu_write       = !isWrite;
        cpu_as          = 1'b0;
        cpu_ds          = dsLow ? 1'b0 : 1'b1;
    endtask

    task automatic endCpuCycle();
        cpu_as          = 1'b1;
        cpu_ds          = 1'b1;
        request_vme_a16 = 1'b0;
        request_vme_a24 = 1'b0;
        request_vme_a40 = 1'b0;
    endtask

    // Request to the first data strobe; returns at the negedge after DS asserts.
    task automatic runToDataPhase(input string tag, input int space, input logic [2:0] fc,
                                  input logic [1:0] siz, input logic a0, input bit isWrite);
        applyStimulus(space, fc, siz, a0, isWrite, 1'b1);
        waitClocks(1 + ADDR_SETUP);
        checkOutput({tag, ":addr_phase"},
                    {vme_as, vme_ctrl_oe, addr_low_oe, a40_cross_oe, 2'b00, vme_address_mod},
                    {1'b1, 1'b1, 1'b0, (space == 2) ? 1'b0 : 1'b1, 2'b00, modelAm(space, fc)});
        waitClocks(1);
        checkOutput({tag, ":as_low"}, {vme_as, vme_ds, a40_cross_oe}, {1'b0, 2'b11, 1'b1});
        waitClocks(DS_DELAY);
        checkOutput({tag, ":data_phase"},
                    {vme_ds, d16_cross_oe, d16_cross_dir, vme_write, vme_lword,
                     data_low_oe, md32_cross_oe},
                    {modelDs(siz, a0), 1'b0, isWrite, !isWrite, 1'b1, 1'b1, 1'b1});
    endtask

    task automatic runTransfer(input string tag, input int space, input logic [2:0] fc,
                               input logic [1:0] siz, input logic a0, input bit isWrite,
                               input int dtackDelay);
        runToDataPhase(tag, space, fc, siz, a0, isWrite);
        waitClocks(dtackDelay);
        vme_dtack = 1'b0;
        waitClocks(2);
        checkOutput({tag, ":dsack_early"}, {31'd0, cpu_dsack_oe}, 32'd0);
        waitClocks(1);
        checkOutput({tag, ":dsack"}, {cpu_dsack_oe, cpu_dsack, cpu_berr_out}, 4'b1011);
        endCpuCycle();
        waitClocks(1);
        checkOutput({tag, ":release"}, {vme_as, vme_ds, cpu_dsack_oe, cpu_dsack},
                    {1'b1, 2'b11, 1'b0, 2'b11});
        vme_dtack = 1'b1;
        waitClocks(2);
        checkOutput({tag, ":hold_bus"}, {31'd0, vme_ctrl_oe}, 32'd1);
        waitClocks(1);
        checkOutput({tag, ":idle"}, {31'd0, vme_ctrl_oe}, 32'd0);
    endtask

    initial begin
        bit dsackSeen;
        bit berrEarly;

        reset = 1'b1;
        bus_acquired = 1'b1;
        vme_dtack = 1'b1;
        vme_berr = 1'b1;
        cpu_write = 1'b1;
        cpu_siz = 2'b00;
        cpu_address_low = 2'b00;
        cpu_fc = 3'b000;
        endCpuCycle();
        waitClocks(3);
        checkOutput("reset_values", outVec, RESET_VEC);
        reset = 1'b0;
        waitClocks(1);

        $display("[TB] A24 supervisor word read");
        runTransfer("a24_sup_read", 1, 3'b101, 2'b10, 1'b0, 1'b0, 5);

        $display("[TB] A16 user byte write, odd address");
        runTransfer("a16_odd_write", 0, 3'b001, 2'b01, 1'b1, 1'b1, 2);

        $display("[TB] randomised transfers");
        for (int i = 0; i < 8; i++) begin
            runTransfer($sformatf("rand%0d", i), $urandom_range(0, 2),
                        3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 8));
        end

        $display("[TB] no DTACK, timeout");
        runToDataPhase("timeout", 1, 3'b110, 2'b10, 1'b0, 1'b0);
        dsackSeen = 1'b0;
        berrEarly = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            waitClocks(1);
            if (cpu_dsack_oe) dsackSeen = 1'b1;
            if (!cpu_berr_out) berrEarly = 1'b1;
        end
        checkOutput("timeout:berr_early", {31'd0, berrEarly}, 32'd0);
        waitClocks(1);
        if (cpu_dsack_oe) dsackSeen = 1'b1;
        checkOutput("timeout:berr", {31'd0, cpu_berr_out}, 32'd0);
        checkOutput("timeout:no_dsack", {31'd0, dsackSeen}, 32'd0);
        endCpuCycle();
        waitClocks(1);
        checkOutput("timeout:release", {vme_as, cpu_berr_out}, 2'b11);
        waitClocks(1);
        checkOutput("timeout:idle", {31'd0, vme_ctrl_oe}, 32'd0);

        $display("[TB] DTACK and BERR together");
        runToDataPhase("both", 0, 3'b101, 2'b00, 1'b0, 1'b0);
        waitClocks(2);
        vme_dtack = 1'b0;
        vme_berr = 1'b0;
        waitClocks(3);
        checkOutput("both:term_err", {cpu_berr_out, cpu_dsack_oe}, 2'b00);
        endCpuCycle();
        vme_dtack = 1'b1;
        vme_berr = 1'b1;
        waitClocks(1);
        checkOutput("both:release", {vme_as, cpu_berr_out, cpu_dsack_oe, vme_ctrl_oe}, 4'b1101);
        waitClocks(2);
        checkOutput("both:idle", {31'd0, vme_ctrl_oe}, 32'd0);

        $display("[TB] CPU abort in STROBE");
        applyStimulus(1, 3'b001, 2'b10, 1'b0, 1'b0, 1'b0);
        waitClocks(2 + ADDR_SETUP);
        checkOutput("abort:as_low", {vme_as, vme_ds}, 3'b011);
        endCpuCycle();
        waitClocks(1);
        checkOutput("abort:release", {vme_as, vme_ds}, 3'b111);
        waitClocks(1);
        checkOutput("abort:idle", {vme_ctrl_oe, vme_ds}, 3'b011);

        $display("[TB] reset during A40 WAIT_ACK");
        runToDataPhase("a40_reset", 2, 3'($urandom_range(0, 7)), 2'b10, 1'b0, 1'b1);
        waitClocks(3);
        reset = 1'b1;
        endCpuCycle();
        waitClocks(1);
        checkOutput("a40_reset:outputs", outVec, RESET_VEC);
        reset = 1'b0;
        waitClocks(1);
        runTransfer("after_reset", 1, 3'b010, 2'b10, 1'b1, 1'b0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
